hyst_speed_comparator: RTL and testbench
========================================

// Module: hyst_speed_comparator
// PURPOSE
//  Multi-bit unsigned magnitude comparator with a tolerance band and persistence filtering.
//  Compares measured speed A against setpoint B and produces debounced one-hot
//  G/Eq/L flags, plus a one-cycle change pulse.
//  Sits between the speed sensor sampler and the cruise-control throttle FSM,
//  which must not see chatter when speed hovers near the setpoint.
// PARAMETERS
//  WIDTH    8  bit width of A, B and TOL (unsigned)
//  PERSIST  4  consecutive qualifying samples required to change state (>=1)
//  CNT_W    localparam = $clog2(PERSIST+1), width of the persistence counter
// PORTS
//  clk      in   1      rising-edge clock, single domain
//  reset    in   1      synchronous, active-high reset
//  en       in   1      sample strobe; A/B/TOL are evaluated only when en=1
//  a        in   WIDTH  measured value
//  b        in   WIDTH  reference value
//  tol      in   WIDTH  tolerance half-band, runtime programmable
//  G        out  1      registered: filtered state is A above the band
//  Eq       out  1      registered: filtered state is A within the band
//  L        out  1      registered: filtered state is A below the band
//  changed  out  1      one-cycle pulse on the edge where the filtered state changes
// BEHAVIOUR
//  - Raw class, combinational, evaluated at WIDTH+1 bits so there is no overflow:
//    RAW_GT if a > b+tol; RAW_LT if a+tol < b; else RAW_EQ.
//    tol=0 gives exact compare; tol >= 2^WIDTH-1 always gives RAW_EQ.
//  - State register st in {ST_EQ, ST_GT, ST_LT}.
//    G/Eq/L decode st directly and are always exactly one-hot.
//  - Registers cand (class) and cnt (CNT_W bits).
//  - Reset (sync, on the edge with reset=1): st=ST_EQ, cand=ST_EQ, cnt=0, changed=0.
//    Outputs after reset: Eq=1, G=0, L=0.
//  - en=0: all state held; changed=0. Samples count per en strobe, not per cycle.
//  - en=1, one of the following on each edge:
//    raw==st          -> cnt=0, cand=st (streak abandoned)
//    raw==cand!=st    -> if cnt+1==PERSIST: st=raw, cnt=0, changed=1; else cnt=cnt+1
//    raw!=cand, !=st  -> cand=raw; if PERSIST==1: st=raw, changed=1, cnt=0; else cnt=1
//  - Latency: flags update on the edge that accepts the PERSIST-th consecutive
//    qualifying sample. They are visible the same cycle after that edge, with no extra stage.
//  - changed is high for exactly the cycle following a state-changing edge, else 0.
//  - Direct GT<->LT transitions are legal: there is no forced pass through EQ.
//  - The streak counter never exceeds PERSIST-1, so there is no wrap.
//  - Reset has priority over en, including mid-streak: pending cnt/cand are discarded.
//  - Inputs may change every cycle. Nothing is latched except st/cand/cnt.
// STRUCTURE
//  - Shared package cmp_pkg: 2-bit state encodings ST_EQ=2'd0, ST_GT=2'd1,
//    ST_LT=2'd2. These are also used for raw class values.
//  - Sub-module band_classify (combinational, WIDTH param):
//    a, b, tol -> 2-bit raw class.
//  - Top: persistence FSM, counter, output decode, changed pulse register.
// TESTING
//  1. Reset, WIDTH=8, PERSIST=4: hold reset 2 cycles -> Eq=1, G=0, L=0, changed=0.
//  2. tol=2, b=100, a=103 with en=1 for 4 cycles -> G=1 after the 4th edge;
//     changed=1 for one cycle; after only 3 cycles Eq is still 1.
//  3. Chatter: a alternates 103/100 each en cycle for 20 cycles -> Eq stays 1, changed never 1.
//  4. Gapped strobes: a=95, b=100, tol=2 with en pulsed every 3rd cycle ->
//     L=1 after the 4th strobe; en=0 cycles do not advance.
//  5. Direct flip, starting with G=1: a=90, b=100 for 4 strobes -> L=1, G=0, changed pulse.
//     Reset asserted after 2 strobes of a new streak -> Eq=1, and the streak is lost.
//  6. Width edges: a=255, b=0, tol=255 -> Eq; a=255, b=0, tol=0 -> G.
//     PERSIST=1 build: a single strobe switches the state.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared class encodings for the hysteresis speed comparator.
// The same 2-bit codes label both the raw band class and the filtered state.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_EQ = 2'd0,
        ST_GT = 2'd1,
        ST_LT = 2'd2
    } cls_e;

    // One-hot {G, Eq, L} view of a class; the unused code falls back to Eq.
    function automatic logic [2:0] cls_to_flags(input cls_e cls);
        logic [2:0] flags;
        case (cls)
            ST_GT:   flags = 3'b100;
            ST_LT:   flags = 3'b001;
            ST_EQ:   flags = 3'b010;
            default: flags = 3'b010;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/band_classify.sv
// Combinational tolerance-band classifier: a vs b with half-band tol.
// Sums are formed one bit wider than the operands so nothing can overflow.
module band_classify
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] tol,
    output cls_e             raw
);

    logic [WIDTH:0] a_ext_s;
    logic [WIDTH:0] b_ext_s;
    logic [WIDTH:0] a_plus_tol_s;
    logic [WIDTH:0] b_plus_tol_s;

    assign a_ext_s      = {1'b0, a};
    assign b_ext_s      = {1'b0, b};
    assign a_plus_tol_s = a_ext_s + {1'b0, tol};
    assign b_plus_tol_s = b_ext_s + {1'b0, tol};

    // Above the band wins first; the two outer tests cannot both hold.
    always_comb begin
        raw = ST_EQ;
        if (a_ext_s > b_plus_tol_s) begin
            raw = ST_GT;
        end else if (a_plus_tol_s < b_ext_s) begin
            raw = ST_LT;
        end else begin
            raw = ST_EQ;
        end
    end

endmodule

// File: rtl/hyst_speed_comparator.sv
// Persistence-filtered magnitude comparator: a raw band class must repeat on
// PERSIST consecutive en strobes before the one-hot G/Eq/L state follows it.
module hyst_speed_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] tol,
    output logic             G,
    output logic             Eq,
    output logic             L,
    output logic             changed
);

    localparam int                CNT_W     = $clog2(PERSIST + 1);
    localparam logic [CNT_W:0]    PERSIST_W = (CNT_W + 1)'(PERSIST);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    cls_e             raw_s;
    cls_e             st_r;
    cls_e             cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic             changed_r;
    logic [2:0]       flags_r;

    cls_e             st_nxt_s;
    cls_e             cand_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             changed_nxt_s;
    logic [CNT_W:0]   cnt_inc_s;

    band_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .a   (a),
        .b   (b),
        .tol (tol),
        .raw (raw_s)
    );

    assign cnt_inc_s = {1'b0, cnt_r} + {CNT_ZERO, 1'b1};

    // Next-state rules for the filter; a sample matching the current state
    // abandons any pending streak toward a different class.
    always_comb begin
        st_nxt_s      = st_r;
        cand_nxt_s    = cand_r;
        cnt_nxt_s     = cnt_r;
        changed_nxt_s = 1'b0;
        if (en) begin
            if (raw_s == st_r) begin
                cand_nxt_s = st_r;
                cnt_nxt_s  = CNT_ZERO;
            end else if (raw_s == cand_r) begin
                if (cnt_inc_s == PERSIST_W) begin
                    st_nxt_s      = raw_s;
                    cnt_nxt_s     = CNT_ZERO;
                    changed_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
                end
            end else begin
                cand_nxt_s = raw_s;
                if (PERSIST == 1) begin
                    st_nxt_s      = raw_s;
                    cnt_nxt_s     = CNT_ZERO;
                    changed_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = CNT_ONE;
                end
            end
        end else begin
            st_nxt_s   = st_r;
            cand_nxt_s = cand_r;
            cnt_nxt_s  = cnt_r;
        end
    end

    // State, streak and output registers; flags are loaded from the next
    // state so they appear on the same edge that accepts the change.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r      <= ST_EQ;
            cand_r    <= ST_EQ;
            cnt_r     <= CNT_ZERO;
            changed_r <= 1'b0;
            flags_r   <= 3'b010;
        end else begin
            st_r      <= st_nxt_s;
            cand_r    <= cand_nxt_s;
            cnt_r     <= cnt_nxt_s;
            changed_r <= changed_nxt_s;
            flags_r   <= cls_to_flags(st_nxt_s);
        end
    end

    assign G       = flags_r[2];
    assign Eq      = flags_r[1];
    assign L       = flags_r[0];
    assign changed = changed_r;

endmodule

// File: tb/tb_hyst_speed_comparator.sv
// Bench for hyst_speed_comparator: directed table, hand sequences, and random
// stimulus against a streak-counting reference model (PERSIST=4 and PERSIST=1).
module tb_hyst_speed_comparator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [7:0] tol = 8'd0;
    logic       g0, eq0, l0, ch0;
    logic       g1, eq1, l1, ch1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hyst_speed_comparator #(.WIDTH(8), .PERSIST(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .tol(tol),
        .G(g0), .Eq(eq0), .L(l0), .changed(ch0));

    hyst_speed_comparator #(.WIDTH(8), .PERSIST(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .tol(tol),
        .G(g1), .Eq(eq1), .L(l1), .changed(ch1));

    // Reference model: 0 = within band, 1 = above, 2 = below.
    int m_state  [2] = '{0, 0};
    int m_target [2] = '{0, 0};
    int m_streak [2] = '{0, 0};
    bit m_pulse  [2] = '{0, 0};
    int m_need   [2] = '{4, 1};

    function automatic int band_of(int av, int bv, int tv);
        if (av > bv + tv) return 1;
        if (av + tv < bv) return 2;
        return 0;
    endfunction

    function automatic void model_step(int k, bit r, bit e, int cls);
        m_pulse[k] = 1'b0;
        if (r) begin
            m_state[k] = 0; m_target[k] = 0; m_streak[k] = 0;
        end else if (e) begin
            if (cls == m_state[k]) begin
                m_streak[k] = 0;
                m_target[k] = m_state[k];
            end else begin
                if (cls == m_target[k]) m_streak[k] = m_streak[k] + 1;
                else begin
                    m_target[k] = cls;
                    m_streak[k] = 1;
                end
                if (m_streak[k] >= m_need[k]) begin
                    m_state[k]  = cls;
                    m_streak[k] = 0;
                    m_pulse[k]  = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [3:0] model_out(int k);
        return {m_state[k] == 1, m_state[k] == 0, m_state[k] == 2, m_pulse[k]};
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got GEqLchg=%b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input int av, input int bv, input int tv);
        int cls;
        reset = r; en = e; a = 8'(av); b = 8'(bv); tol = 8'(tv);
        cls = band_of(av, bv, tv);
        model_step(0, r, e, cls);
        model_step(1, r, e, cls);
        @(posedge clk);
        #1;
        check("model_p4", {g0, eq0, l0, ch0}, model_out(0));
        check("model_p1", {g1, eq1, l1, ch1}, model_out(1));
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        int         a;
        int         b;
        int         tol;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit e, int av, int bv, int tv, logic [3:0] ex);
        vec_t v;
        v.rst = r; v.en = e; v.a = av; v.b = bv; v.tol = tv; v.exp = ex;
        tbl.push_back(v);
    endfunction

    initial begin
        // Reset held two cycles.
        add(1, 0, 0, 0, 0, 4'b0100);
        add(1, 0, 0, 0, 0, 4'b0100);
        // Above band: switches only on the 4th strobe, then the pulse drops.
        add(0, 1, 103, 100, 2, 4'b0100);
        add(0, 1, 103, 100, 2, 4'b0100);
        add(0, 1, 103, 100, 2, 4'b0100);
        add(0, 1, 103, 100, 2, 4'b1001);
        add(0, 0, 103, 100, 2, 4'b1000);
        // Chatter from Eq never qualifies.
        add(1, 0, 0, 0, 0, 4'b0100);
        for (int i = 0; i < 20; i++)
            add(0, 1, (i % 2 == 0) ? 103 : 100, 100, 2, 4'b0100);
        // Gapped strobes below band: idle cycles do not advance the streak.
        for (int s = 0; s < 4; s++) begin
            add(0, 1, 95, 100, 2, (s == 3) ? 4'b0011 : 4'b0100);
            add(0, 0, 95, 100, 2, (s == 3) ? 4'b0010 : 4'b0100);
            add(0, 0, 95, 100, 2, (s == 3) ? 4'b0010 : 4'b0100);
        end

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].tol);
            check("table", {g0, eq0, l0, ch0}, tbl[i].exp);
        end

        // Direct L -> G, then G -> L, without passing through Eq.
        for (int i = 0; i < 4; i++) step(0, 1, 110, 100, 2);
        check("flip_to_g", {g0, eq0, l0, ch0}, 4'b1001);
        for (int i = 0; i < 3; i++) step(0, 1, 90, 100, 2);
        check("flip_pending", {g0, eq0, l0, ch0}, 4'b1000);
        step(0, 1, 90, 100, 2);
        check("flip_to_l", {g0, eq0, l0, ch0}, 4'b0011);
        // Reset mid-streak discards the partial count.
        step(0, 1, 110, 100, 2);
        step(0, 1, 110, 100, 2);
        check("mid_streak", {g0, eq0, l0, ch0}, 4'b0010);
        step(1, 1, 110, 100, 2);
        check("reset_mid", {g0, eq0, l0, ch0}, 4'b0100);
        for (int i = 0; i < 3; i++) step(0, 1, 110, 100, 2);
        check("streak_lost", {g0, eq0, l0, ch0}, 4'b0100);
        step(0, 1, 110, 100, 2);
        check("streak_new", {g0, eq0, l0, ch0}, 4'b1001);

        // Width edges and single-strobe switching.
        step(1, 0, 0, 0, 0);
        step(0, 1, 255, 0, 255);
        check("wide_tol_p4", {g0, eq0, l0, ch0}, 4'b0100);
        check("wide_tol_p1", {g1, eq1, l1, ch1}, 4'b0100);
        step(0, 1, 255, 0, 0);
        check("exact_gt_p1", {g1, eq1, l1, ch1}, 4'b1001);
        check("exact_gt_p4", {g0, eq0, l0, ch0}, 4'b0100);
        step(0, 1, 0, 255, 254);
        check("p1_direct_lt", {g1, eq1, l1, ch1}, 4'b0011);
        step(0, 1, 0, 255, 255);
        check("p1_back_eq", {g1, eq1, l1, ch1}, 4'b0101);

        // Random stimulus concentrated near the band edges.
        for (int i = 0; i < 800; i++) begin
            int bv, av, tv;
            bv = int'($urandom_range(0, 255));
            tv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 4));
            av = bv + int'($urandom_range(0, 14)) - 7;
            if (av < 0) av = 0;
            if (av > 255) av = 255;
            if ($urandom_range(0, 7) == 0) av = int'($urandom_range(0, 255));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, av, bv, tv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
